add_accumulator: RTL and testbench

//   Downstream consumer of the combinational Add stage. Takes a stream of WITH-bit

---
 rtl/add_accumulator.sv | 135 +++++++++++++
 tb/tb_add_accumulator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_accumulator.sv
// add_accumulator: frames COUNT samples through an external Add stage
// and presents the frame sum on a valid/ready output.
//
// Parameters: WITH (data width), COUNT (samples per frame, >= 1)
// Ports:
//   Clk, Rst              clock, async active-high reset
//   InValid/InReady/InData  sample input handshake
//   OperA, OperB          operands to external Add (acc, InData)
//   Result                external Add result (OperA+OperB)
//   OutValid/OutReady/OutSum  frame sum output handshake
//   Busy                  high while accumulating or holding a result
//   OutOvf                sticky frame carry (only with ADD_ACC_OVF_EN)
// Optional feature macro: ADD_ACC_OVF_EN
module add_accumulator #(
  parameter int WITH  = 8,
  parameter int COUNT = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            InValid,
  output logic            InReady,
  input  logic [WITH-1:0] InData,
  output logic [WITH-1:0] OperA,
  output logic [WITH-1:0] OperB,
  input  logic [WITH-1:0] Result,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [WITH-1:0] OutSum,
  output logic            Busy
`ifdef ADD_ACC_OVF_EN
  ,
  output logic            OutOvf
`endif
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [WITH-1:0] acc;
  logic [WITH-1:0] accNext;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cntNext;
  logic            accept;

`ifdef ADD_ACC_OVF_EN
  logic ovf;
  logic ovfNext;
`endif

  assign OperA   = acc;
  assign OperB   = InData;
  assign InReady = (state != DONE);
  assign accept  = InValid & InReady;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      acc   <= accNext;
      cnt   <= cntNext;
    end
  end

`ifdef ADD_ACC_OVF_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovfNext;
    end
  end

  assign OutOvf = ovf;
`endif

  always_comb begin
    stateNext = state;
    accNext   = acc;
    cntNext   = cnt;
    OutValid  = 1'b0;
    OutSum    = '0;
    Busy      = 1'b0;
`ifdef ADD_ACC_OVF_EN
    ovfNext   = ovf;
`endif
    unique case (state)
      IDLE, ACCUM: begin
        Busy = (state == ACCUM);
        if (accept) begin
          accNext = Result;
          cntNext = cnt + 1'b1;
`ifdef ADD_ACC_OVF_EN
          // a wrapped unsigned add yields less than the old sum
          ovfNext = ovf | (Result < acc);
`endif
          if (cnt == LAST) begin
            stateNext = DONE;
          end else begin
            stateNext = ACCUM;
          end
        end
      end
      DONE: begin
        Busy     = 1'b1;
        OutValid = 1'b1;
        OutSum   = acc;
        if (OutReady) begin
          stateNext = IDLE;
          accNext   = '0;
          cntNext   = '0;
`ifdef ADD_ACC_OVF_EN
          ovfNext   = 1'b0;
`endif
        end
      end
      default: begin
        stateNext = IDLE;
        accNext   = '0;
        cntNext   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_add_accumulator.sv
// tb_add_accumulator: table-driven frames with a scoreboard,
// plus hand-written reset, backpressure and gap sequences.
module tb_add_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [7:0] inData = '0;
  logic [7:0] operA;
  logic [7:0] operB;
  logic [7:0] result;
  logic       outValid;
  logic       outReady = 1'b1;
  logic [7:0] outSum;
  logic       busy;
`ifdef ADD_ACC_OVF_EN
  logic       outOvf;
  logic       ovf1;
`endif

  logic       v1 = 1'b0;
  logic       rdy1;
  logic [7:0] d1 = '0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic [7:0] r1;
  logic       ov1;
  logic [7:0] s1;
  logic       busy1;

  assign result = operA + operB;
  assign r1     = a1 + b1;

  always #5 clk = ~clk;

  add_accumulator #(.WITH(8), .COUNT(4)) dut (
    .Clk(clk), .Rst(rst),
    .InValid(inValid), .InReady(inReady),
    .InData(inData),
    .OperA(operA), .OperB(operB),
    .Result(result),
    .OutValid(outValid), .OutReady(outReady),
    .OutSum(outSum), .Busy(busy)
`ifdef ADD_ACC_OVF_EN
    , .OutOvf(outOvf)
`endif
  );

  add_accumulator #(.WITH(8), .COUNT(1)) dut1 (
    .Clk(clk), .Rst(rst),
    .InValid(v1), .InReady(rdy1),
    .InData(d1),
    .OperA(a1), .OperB(b1),
    .Result(r1),
    .OutValid(ov1), .OutReady(1'b1),
    .OutSum(s1), .Busy(busy1)
`ifdef ADD_ACC_OVF_EN
    , .OutOvf(ovf1)
`endif
  );

  typedef struct packed {
    logic [3:0][7:0] s;
    logic [7:0]      sum;
    logic            ovf;
  } vec_t;

  vec_t       tbl[6];
  logic [8:0] sb[$];
  logic [8:0] e;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", outValid, 0);
      end else begin
        e = sb.pop_front();
        chk("sum", outSum, e[7:0]);
`ifdef ADD_ACC_OVF_EN
        chk("ovf", outOvf, e[8]);
`endif
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the accept
  task automatic send(input logic [7:0] d);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    inValid = 1'b1;
    inData  = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = inReady;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", n, 0);
    inValid = 1'b0;
  endtask

  task automatic frame(input logic [3:0][7:0] s,
                       input logic [7:0] sum,
                       input logic ovf);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back({ovf, sum});
      send(s[i]);
    end
    @(negedge clk);
    chk("latency_valid", outValid, 1);
    chk("done_inready", inReady, 0);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] tv[4];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{s: {8'd0, 8'd0, 8'd100, 8'd200},
               sum: 8'd44, ovf: 1'b1};
    tbl[1] = '{s: {8'd4, 8'd3, 8'd2, 8'd1},
               sum: 8'd10, ovf: 1'b0};
    tbl[2] = '{s: {8'd0, 8'd0, 8'd1, 8'd255},
               sum: 8'd0, ovf: 1'b1};
    tbl[3] = '{s: {8'd128, 8'd128, 8'd128, 8'd128},
               sum: 8'd0, ovf: 1'b1};
    tbl[4] = '{s: {8'd40, 8'd30, 8'd20, 8'd10},
               sum: 8'd100, ovf: 1'b0};
    tbl[5] = '{s: {8'd1, 8'd2, 8'd3, 8'd250},
               sum: 8'd0, ovf: 1'b1};
    tv = '{8'd3, 8'd7, 8'd1, 8'd9};

    #12;
    chk("rst_valid", outValid, 0);
    chk("rst_inready", inReady, 1);
    chk("rst_sum", outSum, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    frame({8'd4, 8'd3, 8'd2, 8'd1}, 8'd10, 1'b0);
    @(negedge clk);
    chk("one_cycle_valid", outValid, 0);
    chk("after_inready", inReady, 1);
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      frame(tbl[i].s, tbl[i].sum, tbl[i].ovf);
    end

    outReady = 1'b0;
    frame({8'd5, 8'd5, 8'd5, 8'd5}, 8'd20, 1'b0);
    inValid = 1'b1;
    inData  = 8'd77;
    repeat (6) begin
      @(negedge clk);
      chk("hold_valid", outValid, 1);
      chk("hold_sum", outSum, 20);
      chk("hold_inready", inReady, 0);
    end
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_busy", busy, 0);
    chk("release_inready", inReady, 1);
    chk("release_valid", outValid, 0);
    @(posedge clk);
    #1;
    frame({8'd4, 8'd3, 8'd2, 8'd1}, 8'd10, 1'b0);

    sb.push_back({1'b0, 8'd20});
    for (int i = 0; i < 7; i++) begin
      inValid = (i % 2 == 0);
      inData  = inValid ? tv[i/2] : 8'd50;
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    @(negedge clk);
    chk("gap_valid", outValid, 1);
    @(posedge clk);
    #1;

    send(8'd9);
    send(8'd9);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", outValid, 0);
    chk("mid_rst_inready", inReady, 1);
    chk("mid_rst_sum", outSum, 0);
    chk("mid_rst_busy", busy, 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    frame({8'd1, 8'd1, 8'd1, 8'd1}, 8'd4, 1'b0);

    v1 = 1'b1;
    d1 = 8'd7;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    d1 = 8'd0;
    @(negedge clk);
    chk("c1_valid", ov1, 1);
    chk("c1_sum", s1, 7);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("c1_clear", ov1, 0);

    for (int n = 0; n < 20 && sb.size() != 0; n++) begin
      @(posedge clk);
    end
    chk("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
